// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: default sizes and the
// 2-bit saturating counter encodings used by every table entry.
package branch_predictor_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_ENTRIES = 8;
   localparam int DEF_STAT_W  = 16;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   // Counter value of every entry after reset (weakly not-taken).
   localparam ctr_e CTR_RESET = CTR_WNT;

   // Counter value written when a taken branch claims a new entry.
   localparam ctr_e CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_ctr2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   // Step toward the observed direction, sticking at either end.
   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != CTR_ST) begin
            ctr_o = ctr_i + 2'd1;
         end
      end else begin
         if (ctr_i != CTR_SNT) begin
            ctr_o = ctr_i - 2'd1;
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch looks up combinationally; decode resolves, detects mispredicts
// and trains the table on the following rising edge.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ENTRIES = DEF_ENTRIES,
   parameter int STAT_W  = DEF_STAT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] lookup_pc_F,
   output logic              pred_taken_F,
   output logic [DATA_W-1:0] pred_target_F,
   input  logic              res_valid_D,
   input  logic [DATA_W-1:0] res_pc_D,
   input  logic              res_pred_taken_D,
   input  logic [DATA_W-1:0] res_pred_target_D,
   input  logic              res_taken_D,
   input  logic [DATA_W-1:0] res_target_D,
   output logic              mispredict,
   output logic [DATA_W-1:0] recover_pc,
   output logic [STAT_W-1:0] branch_cnt,
   output logic [STAT_W-1:0] mispredict_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = DATA_W - IDX_W - 1;

   logic              valid_q  [ENTRIES];
   logic              valid_d  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [TAG_W-1:0]  tag_d    [ENTRIES];
   logic [DATA_W-1:0] target_q [ENTRIES];
   logic [DATA_W-1:0] target_d [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];
   logic [1:0]        ctr_d    [ENTRIES];

   logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [STAT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

   logic [IDX_W-1:0]  lk_idx;
   logic [TAG_W-1:0]  lk_tag;
   logic              lk_hit;
   logic [IDX_W-1:0]  res_idx;
   logic [TAG_W-1:0]  res_tag;
   logic              res_hit;
   logic [1:0]        ctr_upd;

   // Bit 0 of a PC never selects an entry because instructions are halfword aligned.
   logic unused_pc_bit0;
   assign unused_pc_bit0 = lookup_pc_F[0] ^ res_pc_D[0];

   assign lk_idx  = lookup_pc_F[IDX_W:1];
   assign lk_tag  = lookup_pc_F[DATA_W-1:IDX_W+1];
   assign res_idx = res_pc_D[IDX_W:1];
   assign res_tag = res_pc_D[DATA_W-1:IDX_W+1];

   sat_ctr2 u_sat_ctr2 (
      .ctr_i   (ctr_q[res_idx]),
      .taken_i (res_taken_D),
      .ctr_o   (ctr_upd)
   );

   // Fetch-side lookup reads the registered table directly, so a same-cycle
   // update is never visible until after the edge.
   always_comb begin
      lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken_F  = lk_hit && ctr_q[lk_idx][1];
      pred_target_F = lk_hit ? target_q[lk_idx] : '0;
   end

   // Decode-side check of the piped prediction against the real outcome.
   always_comb begin
      res_hit    = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
      mispredict = res_valid_D &&
                   ((res_taken_D != res_pred_taken_D) ||
                    (res_taken_D && (res_pred_target_D != res_target_D)));
      recover_pc = '0;
      if (mispredict) begin
         recover_pc = res_taken_D ? res_target_D : (res_pc_D + DATA_W'(2));
      end
   end

   // Training: hits move the counter and refresh the target on taken,
   // taken misses evict whatever lived in that slot.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (res_valid_D) begin
         if (res_hit) begin
            ctr_d[res_idx] = ctr_upd;
            if (res_taken_D) begin
               target_d[res_idx] = res_target_D;
            end
         end else if (res_taken_D) begin
            valid_d[res_idx]  = 1'b1;
            tag_d[res_idx]    = res_tag;
            target_d[res_idx] = res_target_D;
            ctr_d[res_idx]    = CTR_ALLOC;
         end
      end
   end

   // Saturating statistics so long runs never wrap back to small values.
   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (res_valid_D && (branch_cnt_q != '1)) begin
         branch_cnt_d = branch_cnt_q + STAT_W'(1);
      end
      if (mispredict && (mispredict_cnt_q != '1)) begin
         mispredict_cnt_d = mispredict_cnt_q + STAT_W'(1);
      end
   end

   // State register; reset wins over any resolve in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_RESET;
         end
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         valid_q          <= valid_d;
         tag_q            <= tag_d;
         target_q         <= target_d;
         ctr_q            <= ctr_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter DATA_W, default 16: PC/target width.
REQ-002 Parameter ENTRIES, default 8: table entries; power of 2, >=2; IDX_W = log2(ENTRIES).
REQ-003 Parameter STAT_W, default 16: statistics counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 lookup_pc_F  in  DATA_W  fetch-stage PC.
REQ-007 pred_taken_F  out  1  predicted taken for lookup_pc_F.
REQ-008 pred_target_F  out  DATA_W  predicted target for lookup_pc_F.
REQ-009 res_valid_D  in  1  branch (B or BR) resolved in decode this cycle; already qualified by stall/flush.
REQ-010 res_pc_D  in  DATA_W  PC of resolving branch.
REQ-011 res_pred_taken_D / res_pred_target_D  in  1 / DATA_W  prediction piped from fetch.
REQ-012 res_taken_D / res_target_D  in  1 / DATA_W  actual outcome and target.
REQ-013 mispredict  out  1  redirect fetch and flush F/D.
REQ-014 recover_pc  out  DATA_W  correct next PC.
REQ-015 branch_cnt / mispredict_cnt  out  STAT_W  statistics.

Function
REQ-016 Index = pc[IDX_W:1]; tag = pc[DATA_W-1:IDX_W+1]; pc[0] ignored.
REQ-017 Entry = valid bit, tag, target (DATA_W), 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-018 Lookup combinational, zero latency: hit = valid & tag match; pred_taken_F = hit & ctr[1]; pred_target_F = hit ? target : 0.
REQ-019 mispredict combinational, same cycle: res_valid_D & ((res_taken_D != res_pred_taken_D) | (res_taken_D & res_pred_target_D != res_target_D)).
REQ-020 recover_pc = res_taken_D ? res_target_D : res_pc_D + 2 (mod 2^DATA_W); 0 when mispredict low.
REQ-021 Update on edge when res_valid_D. Hit: counter saturating +1 if taken, -1 if not; target written if taken.
REQ-022 Miss and taken: allocate (overwrite) entry: valid=1, tag, target, ctr=10.
REQ-023 Miss and not taken: no table change.
REQ-024 Counter saturates: 11 + taken stays 11; 00 + not-taken stays 00.
REQ-025 Lookup and update on the same index in the same cycle: lookup returns pre-update contents; no bypass.
REQ-026 branch_cnt +1 per res_valid_D; mispredict_cnt +1 per mispredict; both saturate at all-ones.
REQ-027 res_valid_D low: no state change, mispredict low.

Reset
REQ-028 rst high: all valid=0, counters=01, targets/tags=0, statistics=0 at the next edge.
REQ-029 rst has priority over a simultaneous update; a resolve asserted during the reset cycle is dropped.
REQ-030 Outputs after reset: pred_taken_F=0, pred_target_F=0; mispredict follows REQ-019 combinationally.

Structure
REQ-031 Shared package: counter encodings, default DATA_W/ENTRIES/STAT_W, reset counter value.
REQ-032 Sub-module sat_ctr2: 2-bit saturating counter next-state; one instance per update path.
REQ-033 Table in flops (not SRAM) so lookup is asynchronous.

Verification
REQ-034 Post-reset lookup 0x0010 -> pred_taken_F=0, pred_target_F=0.
REQ-035 Resolve pc=0x0010, pred 0, taken to 0x0040 -> mispredict=1, recover_pc=0x0040; next cycle lookup 0x0010 -> taken, 0x0040.
REQ-036 Three more taken resolves at 0x0010 then four not-taken -> counter 10,11,11,11 then 10,01,00,00; pred_taken_F after each update 1,1,1,1,0,0,0.
REQ-037 ENTRIES=8: allocate 0x0010, then taken resolve at 0x0020 (same index, different tag) -> lookup 0x0010 misses, 0x0020 hits.
REQ-038 Resolve not-taken at 0xFFFE with pred taken -> mispredict=1, recover_pc=0x0000 (wrap).
REQ-039 Same-cycle lookup/update of one index returns old value; rst concurrent with res_valid_D -> table empty, counters 0; STAT_W=2 run of 5 branches -> branch_cnt=3.
